// File: rtl/nine_to_one_mux.sv
// nine_to_one_mux: registered 9:1 ALU result selector keyed on the R-type funct field.
// Latency: one clock from funct/data sampling to out/illegal.
// No flow control; a new selection is accepted every cycle.
// Optional build macro NINE_TO_ONE_MUX_HOLD_ON_ILLEGAL_EN: when defined, an illegal
// funct holds the previous out value instead of loading zero.
module nine_to_one_mux (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  funct,
  input  logic [31:0] sll_out,
  input  logic [31:0] srl_out,
  input  logic [31:0] sra_out,
  input  logic [31:0] add_out,
  input  logic [31:0] addu_out,
  input  logic [31:0] and_out,
  input  logic [31:0] or_out,
  input  logic [31:0] sub_out,
  input  logic [31:0] sltu_out,
  output logic [31:0] out,
  output logic        illegal
);

  // MIPS funct encodings of the nine supported operations
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;

  logic [31:0] w_sel_dat;
  logic        w_sel_legal;
  logic [31:0] r_out;
  logic        r_illegal;

  // Decode funct into the selected operand; anything unmatched (including X/Z) is illegal
  always_comb begin
    w_sel_dat   = 32'h0000_0000;
    w_sel_legal = 1'b1;
    case (funct)
      FUNCT_SLL:  w_sel_dat = sll_out;
      FUNCT_SRL:  w_sel_dat = srl_out;
      FUNCT_SRA:  w_sel_dat = sra_out;
      FUNCT_ADD:  w_sel_dat = add_out;
      FUNCT_ADDU: w_sel_dat = addu_out;
      FUNCT_AND:  w_sel_dat = and_out;
      FUNCT_OR:   w_sel_dat = or_out;
      FUNCT_SUB:  w_sel_dat = sub_out;
      FUNCT_SLTU: w_sel_dat = sltu_out;
      default: begin
        w_sel_dat   = 32'h0000_0000;
        w_sel_legal = 1'b0;
      end
    endcase
  end

  // Register the selection; reset wins over any pending select
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= 32'h0000_0000;
      r_illegal <= 1'b0;
    end else if (w_sel_legal) begin
      r_out     <= w_sel_dat;
      r_illegal <= 1'b0;
    end else begin
`ifdef NINE_TO_ONE_MUX_HOLD_ON_ILLEGAL_EN
      r_out     <= r_out;
`else
      r_out     <= 32'h0000_0000;
`endif
      r_illegal <= 1'b1;
    end
  end

  assign out     = r_out;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_nine_to_one_mux.sv
// Self-checking bench for nine_to_one_mux: directed scenarios followed by random
// traffic, all compared against a table-lookup reference model.
module tb_nine_to_one_mux;

  logic        clk;
  logic        rst;
  logic [5:0]  funct;
  logic [31:0] d [9];
  logic [31:0] out;
  logic        illegal;

  int n_vec;
  int n_err;

  // Reference model state: legal codes in port order, and the expected registered outputs
  logic [5:0]  codes [9];
  logic [31:0] exp_out;
  logic        exp_ill;

  nine_to_one_mux dut (
    .clk      (clk),
    .rst      (rst),
    .funct    (funct),
    .sll_out  (d[0]),
    .srl_out  (d[1]),
    .sra_out  (d[2]),
    .add_out  (d[3]),
    .addu_out (d[4]),
    .and_out  (d[5]),
    .or_out   (d[6]),
    .sub_out  (d[7]),
    .sltu_out (d[8]),
    .out      (out),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, update the model from the inputs seen at that edge, then check
  task automatic step(input string tag);
    int idx;
    @(posedge clk);
    idx = -1;
    for (int i = 0; i < 9; i++)
      if (funct == codes[i]) idx = i;
    if (rst) begin
      exp_out = 32'h0;
      exp_ill = 1'b0;
    end else if (idx >= 0) begin
      exp_out = d[idx];
      exp_ill = 1'b0;
    end else begin
`ifndef NINE_TO_ONE_MUX_HOLD_ON_ILLEGAL_EN
      exp_out = 32'h0;
`endif
      exp_ill = 1'b1;
    end
    #1;
    chk({tag, ".out"}, out, exp_out);
    chk({tag, ".illegal"}, {31'h0, illegal}, {31'h0, exp_ill});
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 9; i++) d[i] = 32'(i);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    codes[0] = 6'b000000; codes[1] = 6'b000010; codes[2] = 6'b000011;
    codes[3] = 6'b100000; codes[4] = 6'b100001; codes[5] = 6'b100100;
    codes[6] = 6'b100101; codes[7] = 6'b100010; codes[8] = 6'b101011;
    exp_out = 32'h0;
    exp_ill = 1'b0;
    rst   = 1'b1;
    funct = 6'b100001;
    set_ramp();

    // Reset held for two edges, then first valid result one edge after release
    step("rst0");
    step("rst1");
    chk("rst_out_zero", out, 32'h0);
    rst = 1'b0;
    step("rst_rel");
    chk("rst_rel_addu", out, 32'd4);

    // Back-to-back select changes
    funct = 6'b000000; step("b2b_sll");  chk("b2b_sll_lit", out, 32'd0);
    funct = 6'b100001; step("b2b_addu"); chk("b2b_addu_lit", out, 32'd4);
    funct = 6'b100100; step("b2b_and");  chk("b2b_and_lit", out, 32'd5);

    // Sweep all nine codes in decode order
    for (int i = 0; i < 9; i++) begin
      funct = codes[i];
      step("sweep");
      chk("sweep_lit", out, 32'(i));
    end

    // Illegal code handling
`ifdef NINE_TO_ONE_MUX_HOLD_ON_ILLEGAL_EN
    funct = 6'b100101; step("ill_pre");  chk("ill_pre_lit", out, 32'd6);
    funct = 6'b111111; step("ill_code"); chk("ill_hold_lit", out, 32'd6);
`else
    funct = 6'b000000; step("ill_pre");  chk("ill_pre_lit", out, 32'd0);
    funct = 6'b111111; step("ill_code"); chk("ill_zero_lit", out, 32'd0);
`endif
    chk("ill_flag_lit", {31'h0, illegal}, 32'd1);

    // Reset mid-stream discards the pending selection
    funct = 6'b101011; step("mid_sltu"); chk("mid_sltu_lit", out, 32'd8);
    funct = 6'b100010; rst = 1'b1; step("mid_rst"); chk("mid_rst_lit", out, 32'd0);
    rst = 1'b0; step("mid_sub"); chk("mid_sub_lit", out, 32'd7);

    // Data transparency: full 32 bits, input change without funct change
    funct = 6'b000011; d[2] = 32'hFFFF_FFFF; step("xp0"); chk("xp0_lit", out, 32'hFFFF_FFFF);
    d[2] = 32'h8000_0001; step("xp1"); chk("xp1_lit", out, 32'h8000_0001);
    d[0] = 32'hDEAD_BEEF; d[8] = 32'h1234_5678; step("xp2"); chk("xp2_lit", out, 32'h8000_0001);

    // Random traffic: mostly legal codes, some arbitrary codes, occasional reset
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 9; i++) d[i] = $urandom;
      if ($urandom_range(0, 3) == 0) funct = 6'($urandom);
      else funct = codes[$urandom_range(0, 8)];
      rst = ($urandom_range(0, 19) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
